// File: rtl/pc_gen.sv
// Program-counter generator: boot/run/halt sequencing, fetch handshake,
// prioritised trap/mret/branch redirects with a one-entry stall buffer.
//
// state | meaning
// BOOT  | one settle cycle after reset release, no fetch
// RUN   | PC valid for fetch, redirects and sequential steps applied
// HALT  | debug halt, PC and pending redirect frozen
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              IALIGN       = 4
) (
  input  logic            Clk_Core,
  input  logic            Rst_Core,
  input  logic            Stall,
  input  logic            Branch_Taken,
  input  logic [XLEN-1:0] Branch_Target,
  input  logic            Mret_Req,
  input  logic [XLEN-1:0] Mret_Target,
  input  logic            Trap_Req,
  input  logic            Halt_Req,
  input  logic            Resume,
  input  logic            Fetch_Ready,
  output logic            Fetch_Valid,
  output logic [XLEN-1:0] Program_Count,
  output logic [XLEN-1:0] Program_Count_Off,
  output logic            Misalign_Err,
  output logic [XLEN-1:0] Misalign_Addr,
  output logic            Halted
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t          state;
  logic            pend_v;
  logic [XLEN-1:0] pend_addr;
  logic            accept;
  logic [XLEN-1:0] redir_tgt;
  logic            do_apply;
  logic [XLEN-1:0] apply_addr;
  logic            apply_bad;

  function automatic logic misaligned(input logic [XLEN-1:0] t);
    if (IALIGN == 2) return t[0];
    else             return |t[1:0];
  endfunction

  assign accept            = Fetch_Valid & Fetch_Ready & ~Stall;
  assign redir_tgt         = Mret_Req ? Mret_Target : Branch_Target;
  assign Program_Count_Off = Program_Count + XLEN'(4);

  // A live redirect outranks a buffered one; trap and halt pre-empt both.
  always_comb begin
    do_apply   = 1'b0;
    apply_addr = redir_tgt;
    if (state == RUN && !Trap_Req && !Halt_Req && !Stall) begin
      if (Mret_Req || Branch_Taken) begin
        do_apply = 1'b1;
      end else if (pend_v) begin
        do_apply   = 1'b1;
        apply_addr = pend_addr;
      end
    end
  end

  assign apply_bad = misaligned(apply_addr);

  always_ff @(posedge Clk_Core or posedge Rst_Core) begin
    if (Rst_Core) begin
      state         <= BOOT;
      Program_Count <= RESET_VECTOR;
      Fetch_Valid   <= 1'b0;
      pend_v        <= 1'b0;
      pend_addr     <= '0;
      Misalign_Err  <= 1'b0;
      Misalign_Addr <= '0;
      Halted        <= 1'b0;
    end else begin
      Misalign_Err <= 1'b0;
      case (state)
        BOOT: begin
          state       <= RUN;
          Fetch_Valid <= 1'b1;
        end
        RUN: begin
          if (Trap_Req) begin
            Program_Count <= TRAP_VECTOR;
            pend_v        <= 1'b0;
          end else if (Halt_Req) begin
            state       <= HALT;
            Fetch_Valid <= 1'b0;
            Halted      <= 1'b1;
          end else if (do_apply) begin
            pend_v <= 1'b0;
            if (apply_bad) begin
              Program_Count <= TRAP_VECTOR;
              Misalign_Err  <= 1'b1;
              Misalign_Addr <= apply_addr;
            end else begin
              Program_Count <= apply_addr;
            end
          end else if (Mret_Req || Branch_Taken) begin
            // only reachable under Stall: newest redirect wins the buffer
            pend_v    <= 1'b1;
            pend_addr <= redir_tgt;
          end else if (accept) begin
            Program_Count <= Program_Count + XLEN'(4);
          end
        end
        HALT: begin
          if (Trap_Req) begin
            Program_Count <= TRAP_VECTOR;
            pend_v        <= 1'b0;
            state         <= RUN;
            Fetch_Valid   <= 1'b1;
            Halted        <= 1'b0;
          end else if (Resume) begin
            state       <= RUN;
            Fetch_Valid <= 1'b1;
            Halted      <= 1'b0;
          end
        end
        default: begin
          state       <= BOOT;
          Fetch_Valid <= 1'b0;
          Halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: IALIGN=4 and IALIGN=2 instances share stimulus
// and are checked against a per-cycle reference model of the PC rules.
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;

  typedef struct {
    bit rst, stall, br, mret, trap, halt, resume, fr;
    logic [31:0] bt, mt;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    int          mode;
    bit          pv;
    logic [31:0] pa;
    bit          merr;
    logic [31:0] maddr;
  } mstate_t;

  typedef struct {
    mstate_t m4;
    mstate_t m2;
  } exp_t;

  logic clk = 1'b0;
  logic Rst_Core = 1'b1;
  logic Stall = 0, Branch_Taken = 0, Mret_Req = 0, Trap_Req = 0;
  logic Halt_Req = 0, Resume = 0, Fetch_Ready = 0;
  logic [31:0] Branch_Target = '0, Mret_Target = '0;

  logic fv4, me4, h4, fv2, me2, h2;
  logic [31:0] pc4, off4, ma4, pc2, off2, ma2;

  int errors = 0;
  int checks = 0;
  bit running = 0;
  exp_t sb[$];
  mstate_t m4, m2;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .IALIGN(4)) u4 (
    .Clk_Core(clk), .Rst_Core(Rst_Core), .Stall(Stall),
    .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
    .Mret_Req(Mret_Req), .Mret_Target(Mret_Target), .Trap_Req(Trap_Req),
    .Halt_Req(Halt_Req), .Resume(Resume), .Fetch_Ready(Fetch_Ready),
    .Fetch_Valid(fv4), .Program_Count(pc4), .Program_Count_Off(off4),
    .Misalign_Err(me4), .Misalign_Addr(ma4), .Halted(h4));

  pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .IALIGN(2)) u2 (
    .Clk_Core(clk), .Rst_Core(Rst_Core), .Stall(Stall),
    .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
    .Mret_Req(Mret_Req), .Mret_Target(Mret_Target), .Trap_Req(Trap_Req),
    .Halt_Req(Halt_Req), .Resume(Resume), .Fetch_Ready(Fetch_Ready),
    .Fetch_Valid(fv2), .Program_Count(pc2), .Program_Count_Off(off2),
    .Misalign_Err(me2), .Misalign_Addr(ma2), .Halted(h2));

  // Taking a redirect: an address not a multiple of the alignment traps.
  function automatic mstate_t redirect(mstate_t s, logic [31:0] t, int a);
    mstate_t n = s;
    if ((t % 32'(a)) != 0) begin
      n.pc = TV; n.merr = 1; n.maddr = t;
    end else begin
      n.pc = t;
    end
    return n;
  endfunction

  function automatic mstate_t step(mstate_t s, stim_t i, int a);
    mstate_t n = s;
    n.merr = 0;
    if (i.rst) begin
      n.pc = RV; n.mode = M_BOOT; n.pv = 0; n.pa = 0; n.maddr = 0;
      return n;
    end
    if (s.mode == M_BOOT) begin
      n.mode = M_RUN;
    end else if (s.mode == M_HALT) begin
      if (i.trap) begin
        n.pc = TV; n.pv = 0; n.mode = M_RUN;
      end else if (i.resume) begin
        n.mode = M_RUN;
      end
    end else begin
      if (i.trap) begin
        n.pc = TV; n.pv = 0;
      end else if (i.halt) begin
        n.mode = M_HALT;
      end else if (i.mret || i.br) begin
        if (i.stall) begin
          n.pv = 1; n.pa = i.mret ? i.mt : i.bt;
        end else begin
          n = redirect(n, i.mret ? i.mt : i.bt, a);
          n.pv = 0;
        end
      end else if (s.pv && !i.stall) begin
        n = redirect(n, s.pa, a);
        n.pv = 0;
      end else if (i.fr && !i.stall) begin
        n.pc = s.pc + 32'd4;
      end
    end
    return n;
  endfunction

  function automatic stim_t idle(bit fr);
    stim_t s;
    s.rst = 0; s.stall = 0; s.br = 0; s.mret = 0; s.trap = 0;
    s.halt = 0; s.resume = 0; s.fr = fr; s.bt = '0; s.mt = '0;
    return s;
  endfunction

  task automatic cyc(input stim_t s);
    @(negedge clk);
    Rst_Core = s.rst; Stall = s.stall; Branch_Taken = s.br; Branch_Target = s.bt;
    Mret_Req = s.mret; Mret_Target = s.mt; Trap_Req = s.trap;
    Halt_Req = s.halt; Resume = s.resume; Fetch_Ready = s.fr;
    m4 = step(m4, s, 4);
    m2 = step(m2, s, 2);
    sb.push_back('{m4, m2});
    running = 1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_dut(input string tag, input mstate_t e, input logic [31:0] pc,
                           input logic [31:0] off, input logic fv, input logic h,
                           input logic me, input logic [31:0] ma);
    chk({tag, "_pc"}, pc, e.pc);
    chk({tag, "_pc_off"}, off, e.pc + 32'd4);
    chk({tag, "_fetch_valid"}, {31'd0, fv}, {31'd0, e.mode == M_RUN});
    chk({tag, "_halted"}, {31'd0, h}, {31'd0, e.mode == M_HALT});
    chk({tag, "_misalign_err"}, {31'd0, me}, {31'd0, e.merr});
    chk({tag, "_misalign_addr"}, ma, e.maddr);
  endtask

  // Monitor: one expected record per clock edge once stimulus is flowing.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_dut("ia4", e.m4, pc4, off4, fv4, h4, me4, ma4);
        check_dut("ia2", e.m2, pc2, off2, fv2, h2, me2, ma2);
      end else if (running) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
      end
    end
  end

  initial begin
    stim_t s;
    cyc('{rst: 1, fr: 1, default: 0});
    cyc('{rst: 1, fr: 1, default: 0});
    // boot and sequential fetch up to 0x10
    repeat (5) cyc(idle(1));
    // backpressure
    repeat (3) cyc(idle(0));
    cyc(idle(1));
    // stalled redirects: the newer one replaces the older
    s = idle(1); s.stall = 1; s.br = 1; s.bt = 32'h200; cyc(s);
    s.bt = 32'h300; cyc(s);
    s = idle(1); s.stall = 1; cyc(s);
    repeat (3) cyc(idle(1));
    // trap beats mret/branch under stall and clears the buffer
    s = idle(1); s.stall = 1; s.trap = 1; s.mret = 1; s.mt = 32'h80;
    s.br = 1; s.bt = 32'h40; cyc(s);
    repeat (3) cyc(idle(1));
    // misaligned for IALIGN=4, legal for IALIGN=2
    s = idle(1); s.br = 1; s.bt = 32'h1002; cyc(s);
    repeat (3) cyc(idle(1));
    // misaligned target taken from the stall buffer via mret
    s = idle(1); s.stall = 1; s.mret = 1; s.mt = 32'h2001; cyc(s);
    repeat (2) cyc(idle(1));
    // halt at the top of the address space, then resume and wrap
    s = idle(0); s.br = 1; s.bt = 32'hFFFF_FFFC; cyc(s);
    s = idle(0); s.halt = 1; cyc(s);
    s = idle(0); s.br = 1; s.bt = 32'h500; s.stall = 1; cyc(s);
    cyc(idle(1));
    s = idle(1); s.resume = 1; cyc(s);
    repeat (3) cyc(idle(1));
    // asynchronous reset between edges
    @(posedge clk);
    #3;
    Rst_Core = 1;
    #1;
    chk("async_rst_pc_ia4", pc4, RV);
    chk("async_rst_pc_ia2", pc2, RV);
    chk("async_rst_fv_ia4", {31'd0, fv4}, 32'd0);
    cyc('{rst: 1, fr: 1, default: 0});
    repeat (3) cyc(idle(1));
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      s = idle($urandom_range(0, 9) < 7);
      s.rst    = ($urandom_range(0, 199) == 0);
      s.stall  = ($urandom_range(0, 3) == 0);
      s.br     = ($urandom_range(0, 6) == 0);
      s.mret   = ($urandom_range(0, 19) == 0);
      s.trap   = ($urandom_range(0, 39) == 0);
      s.halt   = ($urandom_range(0, 29) == 0);
      s.resume = ($urandom_range(0, 4) == 0);
      s.bt = $urandom;
      s.mt = $urandom;
      if ($urandom_range(0, 3) != 0) s.bt[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) s.mt[1:0] = 2'b00;
      cyc(s);
    end
    @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
